// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer
//   Stage controller for an in-place radix-2 FFT. A start request runs all
//   log2(N) butterfly stages. Each stage kicks the twiddle mapper with the
//   stage index, waits for its completion pulse (with a watchdog), lets the
//   butterfly pipeline drain, then flips the ping-pong banks.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        asynchronous active-high reset
//   start_i      run request, sampled only in IDLE
//   map_dv_i     mapper completion pulse (honoured only in WAIT_MAP)
//   map_we_i     mapper coefficient-valid strobe
//   map_start_o  one-cycle mapper kick
//   map_stage_o  stage index for the mapper, stable from KICK to NEXT
//   bf_en_o      butterfly enable = map_we_i while in WAIT_MAP
//   rd_bank_o    read bank select; final value is the result bank
//   wr_bank_o    write bank select, always ~rd_bank_o
//   busy_o       high outside IDLE
//   done_o       one-cycle pulse when all stages complete
//   err_o        sticky mapper-timeout flag, cleared by the next accepted start
module fft_stage_sequencer #(
  parameter  int N       = 32,
  parameter  int LATENCY = 3,
  parameter  int TIMEOUT = 2*N,
  localparam int STAGE_W = $clog2(N/4)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               map_dv_i,
  input  logic               map_we_i,
  output logic               map_start_o,
  output logic [STAGE_W-1:0] map_stage_o,
  output logic               bf_en_o,
  output logic               rd_bank_o,
  output logic               wr_bank_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  localparam int NSTAGES = $clog2(N);
  // Stage counter must hold NSTAGES-1 even when the mapper port is narrower.
  localparam int SCNT_W  = (STAGE_W > $clog2(NSTAGES)) ? STAGE_W : $clog2(NSTAGES);
  localparam int WD_W    = $clog2(TIMEOUT + 1);
  localparam int DR_W    = $clog2(LATENCY + 1);

  localparam logic [SCNT_W-1:0] LAST_STAGE = SCNT_W'(NSTAGES - 1);
  localparam logic [WD_W-1:0]   WD_LIMIT   = WD_W'(TIMEOUT - 1);
  localparam logic [DR_W-1:0]   DR_LOAD    = DR_W'(LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_KICK, S_WAIT, S_DRAIN, S_NEXT, S_DONE
  } state_e;

  state_e            state_q;
  logic [SCNT_W-1:0] stage_q;
  logic [WD_W-1:0]   wd_q;
  logic [DR_W-1:0]   drain_q;
  logic              rd_bank_q;
  logic              map_start_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  // Registered outputs are written for the state being entered, so they are
  // valid in the same cycle as that state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      stage_q     <= '0;
      wd_q        <= '0;
      drain_q     <= '0;
      rd_bank_q   <= 1'b0;
      map_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      map_start_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            err_q       <= 1'b0;
            stage_q     <= '0;
            rd_bank_q   <= 1'b0;
            wd_q        <= '0;
            drain_q     <= '0;
            map_start_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= S_KICK;
          end
        end
        S_KICK: begin
          wd_q    <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          wd_q <= wd_q + WD_W'(1);
          // Completion beats a timeout landing in the same cycle.
          if (map_dv_i) begin
            drain_q <= DR_LOAD;
            state_q <= S_DRAIN;
          end else if (wd_q == WD_LIMIT) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            stage_q <= '0;
            state_q <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (drain_q == '0) state_q <= S_NEXT;
          else               drain_q <= drain_q - DR_W'(1);
        end
        S_NEXT: begin
          rd_bank_q <= ~rd_bank_q;
          if (stage_q == LAST_STAGE) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            stage_q     <= stage_q + SCNT_W'(1);
            map_start_q <= 1'b1;
            state_q     <= S_KICK;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          stage_q <= '0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          stage_q <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign map_start_o = map_start_q;
  assign map_stage_o = stage_q[STAGE_W-1:0];
  assign bf_en_o     = (state_q == S_WAIT) & map_we_i;
  assign rd_bank_o   = rd_bank_q;
  assign wr_bank_o   = ~rd_bank_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule
